// File: rtl/qs_stream_chk.sv
// rtl/qs_stream_chk.sv - stream checker: framing, ordering, length and latency of one sorter channel
module qs_stream_chk #(
  parameter int W          = 32,
  parameter int DEPTH      = 4,
  parameter int LEN_W      = 16,
  parameter bit DESCENDING = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [W-1:0]  in_dat,
  input  logic          in_rdy_r,
  input  logic          out_vld_r,
  input  logic          out_sop_r,
  input  logic          out_eop_r,
  input  logic          out_err_r,
  input  logic [W-1:0]  out_dat_r,
  output logic [63:0]   tb_cycle_r,
  output logic [31:0]   pkt_cnt_r,
  output logic          lat_vld_r,
  output logic [31:0]   lat_r,
  output logic          chk_err_r,
  output logic [7:0]    chk_code_r,
  output logic [7:0]    chk_first_r
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_BUSY} st_t;

  // input data only matters for its width
  logic unused_in_dat;
  assign unused_in_dat = ^in_dat;

  st_t in_st, in_st_nx, out_st, out_st_nx;
  logic [63:0]      in_ts_r, in_ts_nx, push_ts;
  logic [LEN_W-1:0] in_len_r, in_len_nx, push_len;
  logic             push_req, e_in_frame;

  logic [LEN_W-1:0] cnt_r, cnt_nx;
  logic [W-1:0]     prev_r, prev_nx;
  logic             ref_r, ref_nx, derr_r, derr_nx, obad_r, obad_nx;
  logic             complete, bypass, pop, do_push;
  logic             e_order, e_out_frame, e_len, e_under, e_over, e_dut;
  logic [7:0]       err_bits;

  logic [63:0]      ts_mem  [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_r;
  logic             fifo_empty, fifo_full;
  logic [63:0]      head_ts;
  logic [LEN_W-1:0] head_len;

  assign fifo_empty = (count_r == '0);
  assign fifo_full  = (count_r == CW'(DEPTH));
  assign head_ts    = ts_mem[rd_ptr];
  assign head_len   = len_mem[rd_ptr];

  // input framing: capture SOP timestamp, count beats, push {ts,len} on EOP
  always_comb begin
    in_st_nx   = in_st;
    in_ts_nx   = in_ts_r;
    in_len_nx  = in_len_r;
    push_req   = 1'b0;
    push_ts    = in_ts_r;
    push_len   = in_len_r;
    e_in_frame = 1'b0;
    if (in_vld && in_rdy_r) begin
      if (in_sop) begin
        e_in_frame = (in_st == S_BUSY);
        in_ts_nx   = tb_cycle_r;
        in_len_nx  = LEN_W'(1);
        if (in_eop) begin
          push_req = 1'b1;
          push_ts  = tb_cycle_r;
          push_len = LEN_W'(1);
          in_st_nx = S_IDLE;
        end else begin
          in_st_nx = S_BUSY;
        end
      end else if (in_st == S_IDLE) begin
        e_in_frame = 1'b1;
      end else begin
        in_len_nx = (&in_len_r) ? in_len_r : in_len_r + 1'b1;
        if (in_eop) begin
          push_req = 1'b1;
          push_ts  = in_ts_r;
          push_len = in_len_nx;
          in_st_nx = S_IDLE;
        end
      end
    end
  end

  // output framing, ordering and completion against the FIFO head;
  // ordering faults are held until the packet ends so a DUT error flag on
  // any later beat can still suppress them
  always_comb begin
    out_st_nx   = out_st;
    cnt_nx      = cnt_r;
    prev_nx     = prev_r;
    ref_nx      = ref_r;
    derr_nx     = derr_r;
    obad_nx     = obad_r;
    complete    = 1'b0;
    bypass      = 1'b0;
    e_order     = 1'b0;
    e_out_frame = 1'b0;
    e_len       = 1'b0;
    e_under     = 1'b0;
    e_dut       = 1'b0;
    if (out_vld_r) begin
      e_dut = out_err_r & (out_sop_r | (out_st == S_BUSY));
      if (out_sop_r) begin
        if (out_st == S_BUSY) begin
          e_out_frame = 1'b1;
          e_order     = obad_r & ~derr_r;
        end
        e_under = fifo_empty;
        ref_nx  = ~fifo_empty;
        cnt_nx  = LEN_W'(1);
        prev_nx = out_dat_r;
        derr_nx = out_err_r;
        obad_nx = 1'b0;
        if (out_eop_r) begin
          complete  = 1'b1;
          bypass    = fifo_empty & push_req;
          out_st_nx = S_IDLE;
        end else begin
          out_st_nx = S_BUSY;
        end
      end else if (out_st == S_IDLE) begin
        e_out_frame = 1'b1;
      end else begin
        obad_nx = obad_r | (DESCENDING ? (out_dat_r > prev_r) : (out_dat_r < prev_r));
        prev_nx = out_dat_r;
        cnt_nx  = (&cnt_r) ? cnt_r : cnt_r + 1'b1;
        derr_nx = derr_r | out_err_r;
        if (out_eop_r) begin
          complete  = 1'b1;
          out_st_nx = S_IDLE;
        end
      end
      if (complete) begin
        e_order = e_order | (obad_nx & ~derr_nx);
        e_len   = ref_nx & ~derr_nx & (cnt_nx != head_len);
      end
    end
  end

  // a bypassed push is consumed by the underflowing single-beat packet
  assign pop      = complete & ref_nx;
  assign do_push  = push_req & ~bypass & (~fifo_full | pop);
  assign e_over   = push_req & fifo_full & ~pop;
  assign err_bits = {1'b0, e_dut, e_over, e_under, e_len, e_out_frame, e_in_frame, e_order};

  // FIFO storage, not reset: occupancy is tracked by count_r
  always_ff @(posedge clk) begin
    if (do_push) begin
      ts_mem[wr_ptr]  <= push_ts;
      len_mem[wr_ptr] <= push_len;
    end
  end

  // state registers, FIFO pointers, counters and sticky error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      in_st       <= S_IDLE;
      out_st      <= S_IDLE;
      in_ts_r     <= '0;
      in_len_r    <= '0;
      cnt_r       <= '0;
      prev_r      <= '0;
      ref_r       <= 1'b0;
      derr_r      <= 1'b0;
      obad_r      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      tb_cycle_r  <= '0;
      pkt_cnt_r   <= '0;
      lat_vld_r   <= 1'b0;
      lat_r       <= '0;
      chk_err_r   <= 1'b0;
      chk_code_r  <= '0;
      chk_first_r <= '0;
    end else begin
      in_st      <= in_st_nx;
      out_st     <= out_st_nx;
      in_ts_r    <= in_ts_nx;
      in_len_r   <= in_len_nx;
      cnt_r      <= cnt_nx;
      prev_r     <= prev_nx;
      ref_r      <= ref_nx;
      derr_r     <= derr_nx;
      obad_r     <= obad_nx;
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count_r    <= count_r + CW'(do_push) - CW'(pop);
      tb_cycle_r <= tb_cycle_r + 64'd1;
      if (complete) pkt_cnt_r <= pkt_cnt_r + 32'd1;
      lat_vld_r  <= pop;
      if (pop) lat_r <= 32'(tb_cycle_r - head_ts);
      chk_code_r <= chk_code_r | err_bits;
      chk_err_r  <= |(chk_code_r | err_bits);
      if (!chk_err_r && (err_bits != 8'h00)) chk_first_r <= err_bits;
    end
  end
endmodule

// File: doc/qs_stream_chk.md
Name: qs_stream_chk

Overview:
- Parametrised, synthesizable-style stream checker that replaces the bare probe and cycle-counter wrapper around the sorter.
- Taps both the unsorted-input and sorted-output handshakes of a qs instance.
- Checks framing, output ordering (ascending or descending), and that each output packet has the same beat count as its input packet.
- Measures per-packet latency from input SOP acceptance to output EOP using a timestamp FIFO.
- One instance is placed per sorter channel in multi-channel benches.

Parameters:
- W, 32, data width of in_dat / out_dat_r.
- DEPTH, 4, number of in-flight packets tracked (timestamp/length FIFO entries); power of two.
- LEN_W, 16, beat-counter width; saturates at all-ones.
- DESCENDING, 0, 0 = output must be non-decreasing, 1 = output must be non-increasing.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  DUT input valid
- in_sop  in  1  DUT input start of packet
- in_eop  in  1  DUT input end of packet
- in_dat  in  W  DUT input data (unused except for width check)
- in_rdy_r  in  1  DUT input ready; beat accepted when in_vld & in_rdy_r
- out_vld_r  in  1  DUT output valid
- out_sop_r  in  1  DUT output start of packet
- out_eop_r  in  1  DUT output end of packet
- out_err_r  in  1  DUT flags packet as errored
- out_dat_r  in  W  DUT output data
- tb_cycle_r  out  64  free-running cycle count
- pkt_cnt_r  out  32  completed output packets
- lat_vld_r  out  1  one-cycle pulse: lat_r valid
- lat_r  out  32  cycles from input SOP accept to output EOP (truncated)
- chk_err_r  out  1  sticky: any error seen
- chk_code_r  out  8  sticky OR of error bits
- chk_first_r  out  8  code of the first error cycle only

Behaviour:
- Reset: all outputs 0; FIFO empty; both FSMs in IDLE; tb_cycle_r restarts at 0. Reset mid-packet discards all tracked state without flagging errors.
- tb_cycle_r increments by 1 every non-reset cycle.
- Error bits:
  - [0] ORDER
  - [1] IN_FRAME
  - [2] OUT_FRAME
  - [3] LEN
  - [4] UNDERFLOW
  - [5] OVERFLOW
  - [6] DUT_ERR
  - [7] reserved 0
- Input FSM (on accepted beat only):
  - IDLE + sop: capture ts = tb_cycle_r, len = 1.
    - If eop is also set: push {ts, 1} and stay IDLE.
    - Otherwise: go to BUSY.
  - IDLE + !sop: IN_FRAME; beat ignored.
  - BUSY + sop: IN_FRAME; restart capture as if in IDLE.
  - BUSY + !sop: len += 1 (saturating). On eop, push {ts, len} and go to IDLE.
  - Push when FIFO full and no same-cycle pop: OVERFLOW; entry dropped.
- Output FSM (on out_vld_r):
  - IDLE + sop:
    - FIFO empty: UNDERFLOW; the packet is still framed but is not length- or latency-checked.
    - FIFO non-empty: head entry is the reference; beat count = 1; prev = out_dat_r; go to BUSY (or complete immediately if eop).
  - IDLE + !sop: OUT_FRAME.
  - BUSY + sop: OUT_FRAME; abandon the current packet without popping; treat the beat as a new SOP.
  - BUSY + !sop: ORDER if (DESCENDING ? out_dat_r > prev : out_dat_r < prev). Then prev = out_dat_r and count += 1.
  - Complete on eop:
    - Pop the head entry.
    - pkt_cnt_r += 1.
    - If count != head len: LEN.
    - lat_vld_r = 1 next cycle, with lat_r = tb_cycle_r - head ts.
  - out_err_r on any beat of a packet: DUT_ERR; ORDER and LEN are suppressed for that packet; the pop still occurs.
- Simultaneous push and pop in the same cycle is legal at any occupancy, including full and empty (bypass: the pushed entry may be popped the same cycle only if the FIFO was empty and the beat is a single-beat output SOP+EOP; that case counts as UNDERFLOW).
- Error register timing:
  - chk_code_r |= bits raised this cycle, registered.
  - chk_first_r is loaded only while chk_err_r == 0.
  - chk_err_r = |chk_code_r (registered, same cycle as chk_code_r).
- Comparisons are unsigned W-bit.
- Latency subtraction is 64-bit, truncated to 32.

Test Plan:
- Single packet in {5,1,3} at cycles 10–12, out {1,3,5} SOP at 20, EOP at 22 -> pkt_cnt_r=1, lat_vld_r pulse with lat_r=12, chk_err_r=0.
- DESCENDING=1, in 4 beats, out {9,7,7,2} -> no error; out {9,7,8,2} -> chk_first_r=8'h01.
- In 3 beats, out 2 beats -> chk_code_r=8'h08; pkt_cnt_r=1.
- DEPTH=4: push 5 packets with no output -> 5th raises OVERFLOW (8'h20). Then drain 4 packets -> no further errors, pkt_cnt_r=4.
- Out SOP with FIFO empty -> 8'h10. Then out beat without SOP in IDLE -> chk_code_r=8'h14, chk_first_r=8'h10.
- out_err_r on a mis-ordered packet -> code 8'h40 only. Assert rst mid-packet -> all outputs 0 next cycle, and the following clean packet passes.
